// File: rtl/uart_frame_pkg.sv
// Shared types and defaults for the UART framing controller.
// UART_FRAME_TIMEOUT_EN (defined at build time) enables the inter-byte timeout.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_HOLD
  } frame_state_e;

  localparam logic [7:0]  DEF_SYNC_BYTE      = 8'hA5;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 104160;

  // 8-bit running checksum; wraps silently.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/uart_frame_ctrl_frame_buf.sv
// Payload store for uart_frame_ctrl: single write port, registered read port.
// Memory is not reset; only the read register clears.
module frame_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                     rd_data <= '0;
    else if (32'(rd_addr) < DEPTH) rd_data <= mem[rd_addr];
    else                           rd_data <= '0;
  end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame controller behind the UART receiver: sync hunt, length/payload/checksum
// collection, hold/ack handoff. Optional timeout under UART_FRAME_TIMEOUT_EN.
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter int unsigned MAX_LEN        = 16
`ifdef UART_FRAME_TIMEOUT_EN
 ,parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         rx_done,
  input  logic [7:0]                   rx_data,
  output logic                         frame_valid,
  output logic [$clog2(MAX_LEN+1)-1:0] frame_len,
  input  logic [$clog2(MAX_LEN)-1:0]   rd_addr,
  output logic [7:0]                   rd_data,
  input  logic                         frame_ack,
  output logic                         err_checksum,
  output logic                         err_length,
  output logic                         err_timeout,
  output logic                         err_overrun
);

  localparam int unsigned LW = $clog2(MAX_LEN+1);
  localparam int unsigned AW = $clog2(MAX_LEN);

  frame_state_e  state;
  logic [LW-1:0] len_q;
  logic [AW-1:0] idx;
  logic [7:0]    sum;
  logic          buf_we;

  assign buf_we = rx_done && (state == ST_PAYLOAD);

  frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (buf_we),
    .wr_addr (idx),
    .wr_data (rx_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tmo_cnt;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_HUNT;
      len_q        <= '0;
      idx          <= '0;
      sum          <= '0;
      frame_valid  <= 1'b0;
      frame_len    <= '0;
      err_checksum <= 1'b0;
      err_length   <= 1'b0;
      err_overrun  <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
      err_timeout  <= 1'b0;
      tmo_cnt      <= '0;
`endif
    end else begin
      err_checksum <= 1'b0;
      err_length   <= 1'b0;
      err_overrun  <= 1'b0;
      case (state)
        ST_HUNT: begin
          if (rx_done && rx_data == SYNC_BYTE) state <= ST_LEN;
        end
        ST_LEN: begin
          if (rx_done) begin
            if (32'(rx_data) > MAX_LEN) begin
              err_length <= 1'b1;
              state      <= ST_HUNT;
            end else begin
              len_q <= LW'(rx_data);
              sum   <= rx_data;
              idx   <= '0;
              state <= (rx_data == 8'h00) ? ST_CSUM : ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (rx_done) begin
            sum <= csum_add(sum, rx_data);
            if (LW'(idx) + LW'(1) == len_q) state <= ST_CSUM;
            else                            idx   <= idx + 1'b1;
          end
        end
        ST_CSUM: begin
          if (rx_done) begin
            if (rx_data == sum) begin
              frame_valid <= 1'b1;
              frame_len   <= len_q;
              state       <= ST_HOLD;
            end else begin
              err_checksum <= 1'b1;
              state        <= ST_HUNT;
            end
          end
        end
        ST_HOLD: begin
          // Bytes arriving while a frame is held (even on the ack cycle) are lost.
          err_overrun <= rx_done;
          if (frame_ack) begin
            frame_valid <= 1'b0;
            state       <= ST_HUNT;
          end
        end
        default: state <= ST_HUNT;
      endcase

`ifdef UART_FRAME_TIMEOUT_EN
      // Placed after the case so expiry overrides the idle-state hold; a byte
      // in the expiry cycle clears the counter and is processed above instead.
      err_timeout <= 1'b0;
      if ((state == ST_LEN || state == ST_PAYLOAD || state == ST_CSUM) && !rx_done) begin
        if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          err_timeout <= 1'b1;
          tmo_cnt     <= '0;
          state       <= ST_HUNT;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end else begin
        tmo_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed, table-driven bench for uart_frame_ctrl.
module tb_uart_frame_ctrl;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned TB_TMO  = 50;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = '0;
  logic       frame_valid;
  logic [4:0] frame_len;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       frame_ack = 1'b0;
  logic       err_checksum, err_length, err_timeout, err_overrun;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  uart_frame_ctrl #(
    .SYNC_BYTE (8'hA5),
    .MAX_LEN   (MAX_LEN)
`ifdef UART_FRAME_TIMEOUT_EN
   ,.TIMEOUT_CYCLES (TB_TMO)
`endif
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_done      (rx_done),
    .rx_data      (rx_data),
    .frame_valid  (frame_valid),
    .frame_len    (frame_len),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .frame_ack    (frame_ack),
    .err_checksum (err_checksum),
    .err_length   (err_length),
    .err_timeout  (err_timeout),
    .err_overrun  (err_overrun)
  );

  typedef logic [7:0] bq_t [$];
  typedef struct {
    int         n;
    logic [7:0] b [20];
    logic       exp_valid;
    int         exp_len;
    logic       exp_cs;
    logic       exp_le;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input bq_t q, input logic v, input int len,
                              input logic cs, input logic le);
    vec_t r;
    r.n = q.size();
    for (int i = 0; i < q.size(); i++) r.b[i] = q[i];
    r.exp_valid = v;
    r.exp_len   = len;
    r.exp_cs    = cs;
    r.exp_le    = le;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge clock);
    rx_done = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clock);
    frame_ack = 1'b1;
    @(negedge clock);
    frame_ack = 1'b0;
    chk("valid_after_ack", int'(frame_valid), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, int'(frame_valid), 0);
    chk({tag, "_len"},   int'(frame_len), 0);
    chk({tag, "_rd"},    int'(rd_data), 0);
    chk({tag, "_errs"},  int'({err_checksum, err_length, err_timeout, err_overrun}), 0);
  endtask

  initial begin
    bq_t q16;
    int  seen;

    vecs.push_back(mk('{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h63}, 1, 3, 0, 0));
    vecs.push_back(mk('{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h64}, 0, 0, 1, 0));
    vecs.push_back(mk('{8'hA5, 8'h00, 8'h00}, 1, 0, 0, 0));
    vecs.push_back(mk('{8'h55, 8'hA5, 8'h11}, 0, 0, 0, 1));
    vecs.push_back(mk('{8'hA5, 8'h02, 8'h11, 8'h22, 8'h35}, 1, 2, 0, 0));
    q16.push_back(8'hA5);
    q16.push_back(8'h10);
    for (int i = 1; i <= 16; i++) q16.push_back(8'(i));
    q16.push_back(8'h98);
    vecs.push_back(mk(q16, 1, 16, 0, 0));
    vecs.push_back(mk('{8'hA5, 8'h11}, 0, 0, 0, 1));
    vecs.push_back(mk('{8'hA5, 8'h02, 8'hFF, 8'hFF, 8'h00}, 1, 2, 0, 0));

    repeat (2) @(negedge clock);
    check_zero_outputs("reset");
    reset = 1'b0;
    @(negedge clock);

    foreach (vecs[v]) begin
      for (int i = 0; i < vecs[v].n; i++) send_byte(vecs[v].b[i]);
      chk($sformatf("v%0d_valid", v), int'(frame_valid), int'(vecs[v].exp_valid));
      chk($sformatf("v%0d_cserr", v), int'(err_checksum), int'(vecs[v].exp_cs));
      chk($sformatf("v%0d_lenerr", v), int'(err_length), int'(vecs[v].exp_le));
      if (vecs[v].exp_valid) chk($sformatf("v%0d_len", v), int'(frame_len), vecs[v].exp_len);
      @(negedge clock);
      chk($sformatf("v%0d_pulse_end", v), int'({err_checksum, err_length}), 0);
      if (vecs[v].exp_valid) begin
        for (int i = 0; i < vecs[v].exp_len; i++) begin
          rd_addr = 4'(i);
          @(negedge clock);
          chk($sformatf("v%0d_rd%0d", v, i), int'(rd_data), int'(vecs[v].b[2+i]));
        end
        do_ack();
      end
    end

    // Stalled partial frame
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    seen = 0;
    for (int c = 0; c < int'(TB_TMO) + 250; c++) begin
      @(negedge clock);
      if (err_timeout) seen++;
    end
`ifdef UART_FRAME_TIMEOUT_EN
    chk("tmo_pulse_count", seen, 1);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
`else
    chk("tmo_pulse_count", seen, 0);
`endif
    send_byte(8'h22);
    send_byte(8'h35);
    chk("tmo_frame_valid", int'(frame_valid), 1);
    chk("tmo_frame_len", int'(frame_len), 2);
    do_ack();

    // Overrun while held, then on the ack cycle
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h42);
    send_byte(8'h43);
    chk("ovr_valid", int'(frame_valid), 1);
    rd_addr = 4'd0;
    send_byte(8'hA5);
    chk("ovr_pulse", int'(err_overrun), 1);
    chk("ovr_len", int'(frame_len), 1);
    chk("ovr_rd", int'(rd_data), 8'h42);
    chk("ovr_still_valid", int'(frame_valid), 1);
    @(negedge clock);
    frame_ack = 1'b1;
    rx_done   = 1'b1;
    rx_data   = 8'hA5;
    @(negedge clock);
    frame_ack = 1'b0;
    rx_done   = 1'b0;
    chk("ovr_ack_pulse", int'(err_overrun), 1);
    chk("ovr_ack_valid", int'(frame_valid), 0);
    send_byte(8'h01);
    send_byte(8'h42);
    send_byte(8'h43);
    chk("ovr_sync_dropped", int'(frame_valid), 0);

    // Back-to-back: SYNC the cycle right after HOLD exits
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h42);
    send_byte(8'h43);
    @(negedge clock);
    frame_ack = 1'b1;
    @(negedge clock);
    frame_ack = 1'b0;
    rx_done   = 1'b1;
    rx_data   = 8'hA5;
    @(negedge clock);
    rx_done   = 1'b0;
    chk("b2b_overrun", int'(err_overrun), 0);
    send_byte(8'h01);
    send_byte(8'h7E);
    send_byte(8'h7F);
    chk("b2b_valid", int'(frame_valid), 1);
    rd_addr = 4'd0;
    @(negedge clock);
    chk("b2b_rd", int'(rd_data), 8'h7E);
    do_ack();

    // Reset mid-payload
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h10);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_zero_outputs("midrst");
    reset = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h30);
    send_byte(8'h63);
    chk("midrst_valid", int'(frame_valid), 1);
    chk("midrst_len", int'(frame_len), 3);
    rd_addr = 4'd2;
    @(negedge clock);
    chk("midrst_rd2", int'(rd_data), 8'h30);
    do_ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
